msdf_ram_bridge: RTL and testbench

//  Parametrised dual-port operand RAM. Avalon-MM slave side gives the host pointer-indexed

---
 rtl/msdf_ram_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_msdf_ram_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/msdf_ram_bridge.sv
// msdf_ram_bridge: dual-port operand RAM with two access ports.
//   Host side (Avalon-MM slave): pointer-indexed block load/unload through a small register map.
//   Arith side: single-cycle access for the MSDF datapath.
// If the host port and the arith port write the same word in the same cycle, the arith data is kept.
module msdf_ram_bridge #(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 11,
    parameter logic [31:0] ID_VAL = 32'h87654321
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [2:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    input  logic [ADDR_W-1:0] addr_arith,
    input  logic [DATA_W-1:0] data_arith,
    input  logic              we_arith,
    output logic [DATA_W-1:0] q_arith
);

    // state   | meaning
    // IDLE    | no read in flight; register reads answered directly
    // RD_WAIT | RAM word for ptr is being fetched, pointer advances here
    // RD_DONE | readdata valid, waitrequest released for one cycle
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] ID_TRN = DATA_W'(ID_VAL);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic              we_q, we_d;
    logic              autoinc_q, autoinc_d;
    logic              wrap_en_q, wrap_en_d;
    logic [1:0]        status_q, status_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [DATA_W-1:0] q_arith_q, q_arith_d;
    logic [DATA_W-1:0] ram_b_q, ram_b_d;

    logic              host_wr_data;
    logic              collision;
    logic              advance;
    logic [ADDR_W:0]   ptr_sum;
    logic [ADDR_W-1:0] adv_ptr;
    logic              adv_wrap;
    logic [DATA_W-1:0] reg_rdata;
    logic [1:0]        status_clr;

    assign host_wr_data = write && (address == 3'd0) && we_q;
    assign collision    = host_wr_data && we_arith && (ptr_q == addr_arith);
    assign advance      = host_wr_data || (state_q == RD_WAIT);
    assign ptr_sum      = {1'b0, ptr_q} + {1'b0, stride_q};

    // Gate waitrequest with resetn so that the stall drops as soon as reset is asserted, even if the master still holds read.
    assign waitrequest = resetn && read && (state_q != RD_DONE);
    assign readdata    = readdata_q;
    assign q_arith     = q_arith_q;

    // Compute the pointer value after one advance: either wrap to 0 past limit, or plain modulo-2**ADDR_W
    always_comb begin
        adv_ptr  = ptr_q;
        adv_wrap = 1'b0;
        if (autoinc_q) begin
            if (wrap_en_q && (ptr_sum > {1'b0, limit_q})) begin
                adv_ptr  = '0;
                adv_wrap = 1'b1;
            end else begin
                adv_ptr = ptr_sum[ADDR_W-1:0];
            end
        end
    end

    // Register read mux for every register except DATA
    always_comb begin
        reg_rdata = '0;
        case (address)
            3'd1:    reg_rdata = DATA_W'(ptr_q);
            3'd2:    reg_rdata = DATA_W'({wrap_en_q, autoinc_q, we_q});
            3'd3:    reg_rdata = ID_TRN;
            3'd4:    reg_rdata = DATA_W'(stride_q);
            3'd5:    reg_rdata = DATA_W'(limit_q);
            3'd6:    reg_rdata = DATA_W'(status_q);
            default: reg_rdata = '0;
        endcase
    end

    // Read FSM next state plus register write decode and pointer/status update
    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        ptr_d      = ptr_q;
        stride_d   = stride_q;
        limit_d    = limit_q;
        we_d       = we_q;
        autoinc_d  = autoinc_q;
        wrap_en_d  = wrap_en_q;
        status_clr = 2'b00;

        case (state_q)
            IDLE: begin
                if (read) begin
                    if (address == 3'd0) begin
                        state_d = RD_WAIT;
                    end else begin
                        readdata_d = reg_rdata;
                        state_d    = RD_DONE;
                    end
                end
            end
            RD_WAIT: begin
                readdata_d = ram_b_q;
                state_d    = RD_DONE;
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (write) begin
            case (address)
                3'd1: ptr_d = writedata[ADDR_W-1:0];
                3'd2: begin
                    we_d      = writedata[0];
                    autoinc_d = writedata[1];
                    wrap_en_d = writedata[2];
                end
                3'd4: stride_d   = writedata[ADDR_W-1:0];
                3'd5: limit_d    = writedata[ADDR_W-1:0];
                3'd6: status_clr = writedata[1:0];
                default: ;
            endcase
        end

        if (advance) begin
            ptr_d = adv_ptr;
        end

        // A flag set in the same cycle as its write-1-to-clear keeps the flag set
        status_d = (status_q & ~status_clr) | {collision, advance && adv_wrap};
    end

    // Arith port read-data mux: on a write the new data is passed straight to q_arith
    always_comb begin
        q_arith_d = we_arith ? data_arith : mem[addr_arith];
    end

    // Host-side RAM read register: capture mem[ptr] when a DATA read starts
    always_comb begin
        ram_b_d = ram_b_q;
        if ((state_q == IDLE) && read && (address == 3'd0)) begin
            ram_b_d = mem[ptr_q];
        end
    end

    // Control and status registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            stride_q   <= ADDR_W'(1);
            limit_q    <= '1;
            we_q       <= 1'b0;
            autoinc_q  <= 1'b1;
            wrap_en_q  <= 1'b0;
            status_q   <= 2'b00;
            readdata_q <= '0;
            q_arith_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            stride_q   <= stride_d;
            limit_q    <= limit_d;
            we_q       <= we_d;
            autoinc_q  <= autoinc_d;
            wrap_en_q  <= wrap_en_d;
            status_q   <= status_d;
            readdata_q <= readdata_d;
            q_arith_q  <= q_arith_d;
        end
    end

    // RAM array and host read register; the RAM contents are not reset.
    // The host read register samples the old word, so the host port reads before the write takes effect.
    always_ff @(posedge clock) begin
        ram_b_q <= ram_b_d;
        if (host_wr_data && !collision) begin
            mem[ptr_q] <= writedata;
        end
        if (we_arith) begin
            mem[addr_arith] <= data_arith;
        end
    end

endmodule

// File: tb/tb_msdf_ram_bridge.sv
// Directed bench for msdf_ram_bridge with a scoreboard of expected read results.
module tb_msdf_ram_bridge;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [10:0] addr_arith;
    logic [31:0] data_arith;
    logic        we_arith;
    logic [31:0] q_arith;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];

    msdf_ram_bridge dut (
        .clock       (clock),
        .resetn      (resetn),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .addr_arith  (addr_arith),
        .data_arith  (data_arith),
        .we_arith    (we_arith),
        .q_arith     (q_arith)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(posedge clock);
        #1 write = 1'b0;
    endtask

    // Optional arith write during the first (IDLE) cycle of the read
    task automatic host_read(input logic [2:0] a, input logic [31:0] exp, input int exp_lat,
                             input string tag, input bit hit = 1'b0,
                             input logic [10:0] ha = '0, input logic [31:0] hd = '0);
        int          n;
        logic [31:0] got;
        sb.push_back(exp);
        @(negedge clock);
        address = a;
        read    = 1'b1;
        if (hit) begin
            we_arith   = 1'b1;
            addr_arith = ha;
            data_arith = hd;
        end
        n = 1;
        #1;
        while (waitrequest === 1'b1 && n < 10) begin
            @(posedge clock);
            #1 we_arith = 1'b0;
            @(negedge clock);
            #1;
            n++;
        end
        got = readdata;
        @(posedge clock);
        #1 read  = 1'b0;
        we_arith = 1'b0;
        check(tag, got, sb.pop_front());
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic arith_read(input logic [10:0] a, input logic [31:0] exp, input string tag);
        sb.push_back(exp);
        @(negedge clock);
        addr_arith = a;
        we_arith   = 1'b0;
        @(posedge clock);
        #1 check(tag, q_arith, sb.pop_front());
    endtask

    initial begin
        resetn     = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        addr_arith = '0;
        data_arith = '0;
        we_arith   = 1'b0;
        #23;
        check("rst_waitreq", {31'd0, waitrequest}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_q_arith", q_arith, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Reset values of the register map
        host_read(3'd3, 32'h87654321, 2, "id");
        host_read(3'd4, 32'd1, 2, "stride_rst");
        host_read(3'd5, 32'd2047, 2, "limit_rst");
        host_read(3'd2, 32'd2, 2, "ctrl_rst");
        host_read(3'd6, 32'd0, 2, "status_rst");
        host_read(3'd1, 32'd0, 2, "ptr_rst");
        host_read(3'd7, 32'd0, 2, "reserved");

        // Block load and unload
        host_write(3'd2, 32'd3);
        host_write(3'd1, 32'd5);
        host_write(3'd0, 32'hA);
        host_write(3'd0, 32'hB);
        host_write(3'd0, 32'hC);
        host_read(3'd1, 32'd8, 2, "ptr_after_wr");
        host_write(3'd1, 32'd5);
        host_read(3'd0, 32'hA, 3, "data5");
        host_read(3'd0, 32'hB, 3, "data6");
        host_read(3'd0, 32'hC, 3, "data7");
        host_read(3'd1, 32'd8, 2, "ptr_after_rd");

        // Stride with limit wrap
        host_write(3'd4, 32'd3);
        host_write(3'd5, 32'd10);
        host_write(3'd2, 32'd7);
        host_write(3'd1, 32'd9);
        host_write(3'd0, 32'h11);
        host_read(3'd1, 32'd0, 2, "ptr_wrapped");
        host_read(3'd6, 32'd1, 2, "status_wrapped");
        arith_read(11'd9, 32'h11, "ram9");
        host_write(3'd6, 32'd1);
        host_read(3'd6, 32'd0, 2, "status_cleared");
        host_write(3'd1, 32'd7);
        host_write(3'd0, 32'h77);
        host_read(3'd1, 32'd10, 2, "ptr_at_limit");
        host_read(3'd6, 32'd0, 2, "status_no_wrap");
        host_write(3'd2, 32'd3);
        host_write(3'd1, 32'd2046);
        host_write(3'd0, 32'h99);
        host_read(3'd1, 32'd1, 2, "ptr_modulo");
        host_read(3'd6, 32'd0, 2, "status_modulo");

        // we=0 ignores DATA writes; autoinc=0 holds ptr
        host_write(3'd4, 32'd1);
        host_write(3'd1, 32'd2);
        host_write(3'd0, 32'h22);
        host_write(3'd2, 32'd2);
        host_write(3'd1, 32'd2);
        host_write(3'd0, 32'h55);
        host_read(3'd1, 32'd2, 2, "ptr_we0");
        host_read(3'd0, 32'h22, 3, "ram2_kept");
        host_read(3'd1, 32'd3, 2, "ptr_rd_adv");
        host_write(3'd2, 32'd0);
        host_write(3'd1, 32'd2);
        host_read(3'd0, 32'h22, 3, "hold_rd1");
        host_read(3'd0, 32'h22, 3, "hold_rd2");
        host_read(3'd1, 32'd2, 2, "ptr_held");

        // Host/arith write collision
        host_write(3'd2, 32'd3);
        host_write(3'd1, 32'd7);
        @(negedge clock);
        address    = 3'd0;
        writedata  = 32'h1;
        write      = 1'b1;
        we_arith   = 1'b1;
        addr_arith = 11'd7;
        data_arith = 32'h2;
        @(posedge clock);
        #1;
        write    = 1'b0;
        we_arith = 1'b0;
        check("q_arith_wf", q_arith, 32'h2);
        host_read(3'd1, 32'd8, 2, "ptr_collision");
        host_read(3'd6, 32'd2, 2, "status_collision");
        arith_read(11'd7, 32'h2, "ram7_arith");
        host_write(3'd1, 32'd7);
        host_read(3'd0, 32'h2, 3, "ram7_host");
        host_write(3'd6, 32'd2);
        host_read(3'd6, 32'd0, 2, "status_coll_clr");

        // Host read sees old data when arith writes the same word at the RAM access
        host_write(3'd1, 32'd12);
        host_write(3'd0, 32'h33);
        host_write(3'd1, 32'd12);
        host_read(3'd0, 32'h33, 3, "rbw_old", 1'b1, 11'd12, 32'h44);
        host_write(3'd1, 32'd12);
        host_read(3'd0, 32'h44, 3, "rbw_new");

        // Reset while a DATA read is in RD_WAIT
        host_write(3'd1, 32'd20);
        @(negedge clock);
        address = 3'd0;
        read    = 1'b1;
        @(posedge clock);
        #1 resetn = 1'b0;
        #1 check("rst_mid_waitreq", {31'd0, waitrequest}, 32'd0);
        read = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        host_read(3'd1, 32'd0, 2, "rst_mid_ptr");
        host_read(3'd2, 32'd2, 2, "rst_mid_ctrl");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
